// File: rtl/count_ctrl_pkg.sv
// count_ctrl shared definitions
// state codes, state width, counter preset
package count_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // BCD value the counter loads on cnt_load
   localparam logic [11:0] PRESET_BCD = 12'h321;

endpackage

// File: rtl/count_ctrl_btn.sv
// btn_debounce: 2-flop sync, stability counter,
// one-clk press pulse on the debounced rising edge
import count_ctrl_pkg::*;

module btn_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam logic [15:0] DB_N = 16'(DB_CYCLES);

   logic        sync1_q, sync2_q;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic [15:0] cnt_q, cnt_d;

   // flip the level after DB_N clocks of a differing synced value
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      if (cnt_q == DB_N) begin
         level_d = ~level_q;
         press_d = ~level_q;
         cnt_d   = '0;
      end else if (sync2_q != level_q) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = '0;
      end
   end

   // synchronizer and debounce registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/done sequencer for the BCD down-counter.
// Optional: AUTO_RELOAD_EN reloads the count after RELOAD_TICKS in DONE.
import count_ctrl_pkg::*;

module count_ctrl #(
   parameter int DB_CYCLES    = 16,
   parameter int BLINK_TICKS  = 4,
   parameter int RELOAD_TICKS = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               btn_start,
   input  logic               btn_clear,
   input  logic               cnt_zero,
   output logic               cnt_clr,
   output logic               cnt_load,
   output logic               cnt_step,
   output logic [STATE_W-1:0] state,
   output logic               busy,
   output logic               alarm
);

   localparam logic [7:0] BLINK_MAX = 8'(BLINK_TICKS - 1);

   state_e     state_q, state_d;
   logic       clr_q, clr_d;
   logic       load_q, load_d;
   logic       step_q, step_d;
   logic       alarm_q, alarm_d;
   logic [7:0] blink_q, blink_d;
   logic       start_p, clear_p;
   logic       tick_ok;

`ifdef AUTO_RELOAD_EN
   localparam logic [7:0] RL_MAX = 8'(RELOAD_TICKS - 1);
   logic [7:0] rl_q, rl_d;
`endif

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
      .clk_i   (clk),
      .rst_ni  (reset),
      .btn_i   (btn_start),
      .press_o (start_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
      .clk_i   (clk),
      .rst_ni  (reset),
      .btn_i   (btn_clear),
      .press_o (clear_p)
   );

   // a press in the same cycle swallows the tick
   assign tick_ok = tick & ~start_p & ~clear_p;

   // next state, strobes and alarm blink
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      step_d  = 1'b0;
      alarm_d = alarm_q;
      blink_d = blink_q;
`ifdef AUTO_RELOAD_EN
      rl_d    = rl_q;
`endif
      if (clear_p) begin
         state_d = ST_IDLE;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (start_p) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN: begin
               if (start_p) begin
                  state_d = ST_PAUSE;
               end else if (tick_ok) begin
                  if (cnt_zero) state_d = ST_DONE;
                  else          step_d  = 1'b1;
               end
            end
            ST_PAUSE: if (start_p) state_d = ST_RUN;
            ST_DONE: begin
               if (start_p) begin
                  state_d = ST_IDLE;
               end else if (tick_ok) begin
                  if (blink_q == BLINK_MAX) begin
                     blink_d = '0;
                     alarm_d = ~alarm_q;
                  end else begin
                     blink_d = blink_q + 8'd1;
                  end
`ifdef AUTO_RELOAD_EN
                  if (rl_q == RL_MAX) state_d = ST_LOAD;
                  else                rl_d    = rl_q + 8'd1;
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (state_d == ST_DONE && state_q != ST_DONE) begin
         alarm_d = 1'b1;
         blink_d = '0;
`ifdef AUTO_RELOAD_EN
         rl_d    = '0;
`endif
      end
      if (state_d != ST_DONE) alarm_d = 1'b0;
      load_d = (state_d == ST_LOAD);
   end

   // state and registered strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         clr_q   <= 1'b0;
         load_q  <= 1'b0;
         step_q  <= 1'b0;
         alarm_q <= 1'b0;
         blink_q <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         load_q  <= load_d;
         step_q  <= step_d;
         alarm_q <= alarm_d;
         blink_q <= blink_d;
      end
   end

`ifdef AUTO_RELOAD_EN
   // ticks spent in DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rl_q <= '0;
      else        rl_q <= rl_d;
   end
`endif

   assign cnt_clr  = clr_q;
   assign cnt_load = load_q;
   assign cnt_step = step_q;
   assign state    = state_q;
   assign alarm    = alarm_q;
   assign busy     = (state_q == ST_LOAD) |
                     (state_q == ST_RUN)  |
                     (state_q == ST_PAUSE);

endmodule
